sd_path_arbiter: RTL and testbench
==================================

SD_PATH_ARBITER -- requirements
Module: sd_path_arbiter

Interface
REQ-001 Parameter IDLE_CYCLES, default 64: consecutive cycles of host spi_ss high before a pending switch may proceed (range 1..65535).
REQ-002 Parameter GAP_CYCLES, default 16: cycles both cards stay deselected between old and new routing (range 1..255).
REQ-003 Parameter LED_HOLD, default 1_000_000: activity LED stretch in clk_sys cycles (range 1..2^24-1).
REQ-004 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 img_mounted  in  1  single-cycle strobe: virtual image mounted or unmounted.
REQ-007 img_size  in  32  image size, valid with img_mounted; nonzero means virtual target.
REQ-008 spi_ss, spi_sck, spi_mosi  in  1 each  host-side SPI from the computer core.
REQ-009 spi_miso  out  1  host-side MISO.
REQ-010 vsd_ss, vsd_sck, vsd_mosi  out  1 each  to virtual SD emulator; vsd_miso  in  1.
REQ-011 SD_CS, SD_SCK, SD_MOSI  out  1 each  physical card pins; SD_MISO  in  1.
REQ-012 vsd_sel  out  1  committed routing (1 = virtual); busy  out  1  switch in progress; led_act  out  1  drive activity.

Function
REQ-013 FSM states: S_RUN (routing = committed sel), S_DRAIN (switch pending, routing unchanged), S_GAP (both deselected).
REQ-014 img_mounted in any state latches target <= (img_size != 0); only the last strobe counts.
REQ-015 S_RUN: leave for S_DRAIN next cycle when target != sel; target == sel causes no state change.
REQ-016 S_DRAIN: 16-bit idle counter increments while spi_ss=1, clears to 0 on any spi_ss=0 cycle; reaching IDLE_CYCLES moves to S_GAP and loads the gap counter.
REQ-017 S_GAP: all card outputs deselected for exactly GAP_CYCLES cycles, then sel <= target, state <= S_RUN; if target equals old sel, the transition still completes with sel unchanged.
REQ-018 Switching never begins while spi_ss=0; a host transaction is never split across cards.
REQ-019 Routing is combinational from registered sel/state: zero-cycle latency host->card and card->host.
REQ-020 Selected card: ss/sck/mosi = host signals; spi_miso = that card's MISO.
REQ-021 Deselected card: ss/CS=1, sck=0, mosi=0.
REQ-022 In S_GAP spi_miso=1 (idle bus level).
REQ-023 busy = 1 in S_DRAIN and S_GAP, else 0.
REQ-024 led_act: 24-bit counter reloads to LED_HOLD on every cycle spi_ss=0 in S_RUN or S_DRAIN, decrements to 0 otherwise, saturating at 0; led_act = (counter != 0).
REQ-025 Counters never wrap; idle counter saturates at IDLE_CYCLES.

Reset
REQ-026 Reset takes priority over img_mounted: state S_RUN, sel=0 (physical), target=0, all counters 0.
REQ-027 Output values during and after reset: vsd_sel=0, busy=0, led_act=0, vsd_ss=1, vsd_sck=0, vsd_mosi=0; the physical card is routed to the host.
REQ-028 Reset mid-switch abandons the pending target; no S_GAP is completed.

Structure
REQ-029 Shared package sd_path_pkg holds the state enum and the default constants IDLE_CYCLES, GAP_CYCLES and LED_HOLD.
REQ-030 A single sub-module, pulse_stretch, implements REQ-024; everything else stays flat.

Verification
REQ-031 Reset, then mount with img_size=0x00100000 while spi_ss=1 -> busy rises next cycle; vsd_sel=1 exactly 1+64+16 cycles later; SD_CS=1 during the gap.
REQ-032 Mount (nonzero) during a spi_ss=0 burst of 200 cycles -> vsd_sel stays 0 until 64 idle cycles after ss rises plus 16 gap cycles; no SD_SCK edge is missing from the burst.
REQ-033 Mount nonzero then mount size 0 within 10 cycles -> switch completes with vsd_sel=0, busy pulses high for the full duration then returns to 0.
REQ-034 vsd_sel=1, host toggles sck with vsd_miso=0, SD_MISO=1 -> spi_miso=0 the same cycle; SD_SCK held at 0 and SD_CS held at 1.
REQ-035 Reset asserted in S_GAP -> next cycle busy=0, vsd_sel=0, and the physical card is routed.
REQ-036 With LED_HOLD=100, one spi_ss=0 cycle -> led_act high for exactly 100 cycles after ss rises, then 0.

Source files
------------

// File: rtl/sd_path_arbiter_pkg.sv
// Shared types and default timing constants for the SD card path arbiter.
// Counter widths bound the legal range of each timing parameter.
package sd_path_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_GAP   = 2'd2
  } sd_state_e;

  localparam int IDLE_CYCLES_DEF = 64;
  localparam int GAP_CYCLES_DEF  = 16;
  localparam int LED_HOLD_DEF    = 1_000_000;

  localparam int IDLE_W = 16;
  localparam int GAP_W  = 8;
  localparam int LED_W  = 24;

endpackage

// File: rtl/sd_path_arbiter_if.sv
// Host, virtual-emulator and physical-card SPI lines plus mount/status signals.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface sd_path_arbiter_if;

  logic        img_mounted;
  logic [31:0] img_size;

  logic spi_ss;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;

  logic vsd_ss;
  logic vsd_sck;
  logic vsd_mosi;
  logic vsd_miso;

  logic SD_CS;
  logic SD_SCK;
  logic SD_MOSI;
  logic SD_MISO;

  logic vsd_sel;
  logic busy;
  logic led_act;

  modport slave (
    input  img_mounted, img_size,
    input  spi_ss, spi_sck, spi_mosi,
    output spi_miso,
    output vsd_ss, vsd_sck, vsd_mosi,
    input  vsd_miso,
    output SD_CS, SD_SCK, SD_MOSI,
    input  SD_MISO,
    output vsd_sel, busy, led_act
  );

  modport master (
    output img_mounted, img_size,
    output spi_ss, spi_sck, spi_mosi,
    input  spi_miso,
    input  vsd_ss, vsd_sck, vsd_mosi,
    output vsd_miso,
    input  SD_CS, SD_SCK, SD_MOSI,
    output SD_MISO,
    input  vsd_sel, busy, led_act
  );

endinterface

// File: rtl/sd_path_arbiter_pulse_stretch.sv
// Retriggerable down-counter that stretches short activity pulses for an LED.
module pulse_stretch #(
  parameter int HOLD  = 1_000_000,
  parameter int CNT_W = 24
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic trig,
  output logic active
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD);

  logic [CNT_W-1:0] cnt;

  // Reload on every trigger cycle, otherwise count down and park at zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
    end else if (trig) begin
      cnt <= HOLD_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/sd_path_arbiter.sv
// Routes the host SPI port to either the physical SD card or the virtual image
// emulator, switching only after the host bus has been idle and with a dead gap.
module sd_path_arbiter
  import sd_path_pkg::*;
#(
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int LED_HOLD    = LED_HOLD_DEF
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  sd_path_arbiter_if.slave     sd
);

  localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);

  sd_state_e         state, state_nxt;
  logic              sel, sel_nxt;
  logic              target, target_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;

  logic in_gap;
  logic route_vsd;
  logic route_phy;
  logic led_trig;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_RUN;
      sel      <= 1'b0;
      target   <= 1'b0;
      idle_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      target   <= target_nxt;
      idle_cnt <= idle_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

  // The most recent mount strobe always wins, whatever the switch progress.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    idle_nxt   = '0;
    gap_nxt    = '0;
    target_nxt = sd.img_mounted ? (sd.img_size != 32'd0) : target;

    case (state)
      S_RUN: begin
        if (target != sel) begin
          state_nxt = S_DRAIN;
        end
      end

      // Any host select restarts the idle window, so a transaction is never split.
      S_DRAIN: begin
        if (sd.spi_ss) begin
          if (idle_cnt >= IDLE_LAST) begin
            state_nxt = S_GAP;
            idle_nxt  = IDLE_LIM;
            gap_nxt   = GAP_LOAD;
          end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
          end
        end
      end

      S_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_nxt = S_RUN;
          sel_nxt   = target;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

  assign in_gap    = (state == S_GAP);
  assign route_vsd = !in_gap && sel;
  assign route_phy = !in_gap && !sel;

  // Pure muxing on registered state keeps both directions free of latency.
  assign sd.vsd_ss   = route_vsd ? sd.spi_ss   : 1'b1;
  assign sd.vsd_sck  = route_vsd ? sd.spi_sck  : 1'b0;
  assign sd.vsd_mosi = route_vsd ? sd.spi_mosi : 1'b0;

  assign sd.SD_CS    = route_phy ? sd.spi_ss   : 1'b1;
  assign sd.SD_SCK   = route_phy ? sd.spi_sck  : 1'b0;
  assign sd.SD_MOSI  = route_phy ? sd.spi_mosi : 1'b0;

  assign sd.spi_miso = in_gap ? 1'b1 : (sel ? sd.vsd_miso : sd.SD_MISO);

  assign sd.vsd_sel  = sel;
  assign sd.busy     = (state != S_RUN);

  assign led_trig = !in_gap && !sd.spi_ss;

  pulse_stretch #(
    .HOLD  (LED_HOLD),
    .CNT_W (LED_W)
  ) u_led (
    .clk_sys (clk_sys),
    .reset   (reset),
    .trig    (led_trig),
    .active  (sd.led_act)
  );

endmodule

// File: tb/tb_sd_path_arbiter.sv
// Directed bench for sd_path_arbiter with IDLE_CYCLES=64, GAP_CYCLES=16, LED_HOLD=100.
module tb_sd_path_arbiter;

  logic clk_sys = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sd_path_arbiter_if sd();

  sd_path_arbiter #(
    .IDLE_CYCLES (64),
    .GAP_CYCLES  (16),
    .LED_HOLD    (100)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .sd      (sd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] size);
    sd.img_mounted = 1'b1;
    sd.img_size    = size;
    tick();
    sd.img_mounted = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    sd.spi_sck  = 1'b1;
    sd.spi_mosi = 1'b1;
    sd.spi_ss   = 1'b0;
    sd.SD_MISO  = 1'b1;
    #1;
    checks++; if (sd.vsd_sel !== 1'b0) begin errors++; $display("FAIL rst_vsd_sel got %b want 0", sd.vsd_sel); end
    checks++; if (sd.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", sd.busy); end
    checks++; if (sd.led_act !== 1'b0) begin errors++; $display("FAIL rst_led got %b want 0", sd.led_act); end
    checks++; if (sd.vsd_ss !== 1'b1) begin errors++; $display("FAIL rst_vsd_ss got %b want 1", sd.vsd_ss); end
    checks++; if (sd.vsd_sck !== 1'b0) begin errors++; $display("FAIL rst_vsd_sck got %b want 0", sd.vsd_sck); end
    checks++; if (sd.vsd_mosi !== 1'b0) begin errors++; $display("FAIL rst_vsd_mosi got %b want 0", sd.vsd_mosi); end
    checks++; if (sd.SD_CS !== 1'b0) begin errors++; $display("FAIL rst_sd_cs got %b want 0", sd.SD_CS); end
    checks++; if (sd.SD_SCK !== 1'b1) begin errors++; $display("FAIL rst_sd_sck got %b want 1", sd.SD_SCK); end
    checks++; if (sd.SD_MOSI !== 1'b1) begin errors++; $display("FAIL rst_sd_mosi got %b want 1", sd.SD_MOSI); end
    checks++; if (sd.spi_miso !== 1'b1) begin errors++; $display("FAIL rst_miso got %b want 1", sd.spi_miso); end
    sd.spi_ss   = 1'b1;
    sd.spi_sck  = 1'b0;
    sd.spi_mosi = 1'b0;
    sd.SD_MISO  = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (sd.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", sd.busy); end
    checks++; if (sd.led_act !== 1'b0) begin errors++; $display("FAIL post_rst_led got %b want 0", sd.led_act); end
    checks++; if (sd.SD_CS !== 1'b1) begin errors++; $display("FAIL post_rst_sd_cs got %b want 1", sd.SD_CS); end
  endtask

  task automatic test_switch();
    int first_sel;
    first_sel = -1;
    do_reset();
    strobe(32'h0010_0000);
    checks++; if (sd.busy !== 1'b0) begin errors++; $display("FAIL sw_busy_k0 got %b want 0", sd.busy); end
    for (int k = 1; k <= 90; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (sd.busy !== 1'b1) begin errors++; $display("FAIL sw_busy_k1 got %b want 1", sd.busy); end
      end
      if (k == 70) begin
        sd.spi_ss   = 1'b0;
        sd.spi_sck  = 1'b1;
        sd.SD_MISO  = 1'b0;
        sd.vsd_miso = 1'b0;
        #1;
        checks++; if (sd.SD_CS !== 1'b1) begin errors++; $display("FAIL gap_sd_cs got %b want 1", sd.SD_CS); end
        checks++; if (sd.SD_SCK !== 1'b0) begin errors++; $display("FAIL gap_sd_sck got %b want 0", sd.SD_SCK); end
        checks++; if (sd.vsd_ss !== 1'b1) begin errors++; $display("FAIL gap_vsd_ss got %b want 1", sd.vsd_ss); end
        checks++; if (sd.spi_miso !== 1'b1) begin errors++; $display("FAIL gap_miso got %b want 1", sd.spi_miso); end
        sd.spi_ss  = 1'b1;
        sd.spi_sck = 1'b0;
      end
      if (sd.vsd_sel === 1'b1 && first_sel < 0) first_sel = k;
    end
    checks++; if (first_sel != 81) begin errors++; $display("FAIL sw_sel_cycle got %0d want 81", first_sel); end
    checks++; if (sd.busy !== 1'b0) begin errors++; $display("FAIL sw_busy_end got %b want 0", sd.busy); end
  endtask

  task automatic test_route_virtual();
    logic s;
    sd.spi_ss   = 1'b0;
    sd.vsd_miso = 1'b0;
    sd.SD_MISO  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = (i != 1);
      sd.spi_sck = s;
      #1;
      checks++; if (sd.spi_miso !== 1'b0) begin errors++; $display("FAIL vr_miso got %b want 0", sd.spi_miso); end
      checks++; if (sd.SD_SCK !== 1'b0) begin errors++; $display("FAIL vr_sd_sck got %b want 0", sd.SD_SCK); end
      checks++; if (sd.SD_CS !== 1'b1) begin errors++; $display("FAIL vr_sd_cs got %b want 1", sd.SD_CS); end
      checks++; if (sd.vsd_sck !== s) begin errors++; $display("FAIL vr_vsd_sck got %b want %b", sd.vsd_sck, s); end
      checks++; if (sd.vsd_ss !== 1'b0) begin errors++; $display("FAIL vr_vsd_ss got %b want 0", sd.vsd_ss); end
      tick();
    end
    sd.vsd_miso = 1'b1;
    #1;
    checks++; if (sd.spi_miso !== 1'b1) begin errors++; $display("FAIL vr_miso_hi got %b want 1", sd.spi_miso); end
    sd.spi_ss   = 1'b1;
    sd.spi_sck  = 1'b0;
    sd.vsd_miso = 1'b0;
    sd.SD_MISO  = 1'b0;
  endtask

  task automatic test_burst();
    int   first_sel;
    logic s;
    int   sck_bad;
    first_sel = -1;
    sck_bad   = 0;
    do_reset();
    sd.spi_ss = 1'b0;
    for (int k = 0; k < 200; k++) begin
      s = k[0];
      sd.spi_sck  = s;
      sd.spi_mosi = k[1];
      if (k == 10) begin
        sd.img_mounted = 1'b1;
        sd.img_size    = 32'h0010_0000;
      end
      #1;
      if (sd.SD_SCK !== s || sd.SD_CS !== 1'b0 || sd.vsd_sel !== 1'b0) sck_bad++;
      tick();
      sd.img_mounted = 1'b0;
    end
    checks++; if (sck_bad != 0) begin errors++; $display("FAIL burst_sck_lost got %0d bad cycles want 0", sck_bad); end
    checks++; if (sd.busy !== 1'b1) begin errors++; $display("FAIL burst_busy got %b want 1", sd.busy); end
    sd.spi_ss   = 1'b1;
    sd.spi_sck  = 1'b0;
    sd.spi_mosi = 1'b0;
    for (int f = 1; f <= 100; f++) begin
      tick();
      if (sd.vsd_sel === 1'b1 && first_sel < 0) first_sel = f;
    end
    checks++; if (first_sel != 80) begin errors++; $display("FAIL burst_sel_cycle got %0d want 80", first_sel); end
  endtask

  task automatic test_cancel();
    int rise;
    int fall;
    int high_cnt;
    int sel_seen;
    rise = -1; fall = -1; high_cnt = 0; sel_seen = 0;
    do_reset();
    strobe(32'h0010_0000);
    for (int k = 1; k <= 100; k++) begin
      if (k == 5) begin
        sd.img_mounted = 1'b1;
        sd.img_size    = 32'd0;
      end
      tick();
      sd.img_mounted = 1'b0;
      if (sd.busy === 1'b1) begin
        high_cnt++;
        if (rise < 0) rise = k;
      end else if (rise >= 0 && fall < 0) begin
        fall = k;
      end
      if (sd.vsd_sel !== 1'b0) sel_seen++;
    end
    checks++; if (rise != 1) begin errors++; $display("FAIL cancel_rise got %0d want 1", rise); end
    checks++; if (fall != 81) begin errors++; $display("FAIL cancel_fall got %0d want 81", fall); end
    checks++; if (high_cnt != 80) begin errors++; $display("FAIL cancel_busy_len got %0d want 80", high_cnt); end
    checks++; if (sel_seen != 0) begin errors++; $display("FAIL cancel_sel got %0d cycles want 0", sel_seen); end
  endtask

  task automatic test_reset_in_gap();
    int busy_seen;
    busy_seen = 0;
    do_reset();
    strobe(32'h0010_0000);
    for (int k = 1; k <= 70; k++) tick();
    checks++; if (sd.busy !== 1'b1) begin errors++; $display("FAIL rg_busy_gap got %b want 1", sd.busy); end
    reset = 1'b1;
    tick();
    checks++; if (sd.busy !== 1'b0) begin errors++; $display("FAIL rg_busy got %b want 0", sd.busy); end
    checks++; if (sd.vsd_sel !== 1'b0) begin errors++; $display("FAIL rg_sel got %b want 0", sd.vsd_sel); end
    sd.spi_ss = 1'b0;
    #1;
    checks++; if (sd.SD_CS !== 1'b0) begin errors++; $display("FAIL rg_sd_cs got %b want 0", sd.SD_CS); end
    checks++; if (sd.vsd_ss !== 1'b1) begin errors++; $display("FAIL rg_vsd_ss got %b want 1", sd.vsd_ss); end
    reset = 1'b0;
    sd.spi_ss = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (sd.busy !== 1'b0 || sd.vsd_sel !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL rg_abandon got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_led();
    int on_cnt;
    on_cnt = 0;
    do_reset();
    checks++; if (sd.led_act !== 1'b0) begin errors++; $display("FAIL led_idle got %b want 0", sd.led_act); end
    sd.spi_ss = 1'b0;
    tick();
    sd.spi_ss = 1'b1;
    #1;
    checks++; if (sd.led_act !== 1'b1) begin errors++; $display("FAIL led_on got %b want 1", sd.led_act); end
    if (sd.led_act === 1'b1) on_cnt++;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (sd.led_act === 1'b1) on_cnt++;
    end
    checks++; if (on_cnt != 100) begin errors++; $display("FAIL led_len got %0d want 100", on_cnt); end
    checks++; if (sd.led_act !== 1'b0) begin errors++; $display("FAIL led_off got %b want 0", sd.led_act); end
  endtask

  initial begin
    reset          = 1'b1;
    sd.img_mounted = 1'b0;
    sd.img_size    = 32'd0;
    sd.spi_ss      = 1'b1;
    sd.spi_sck     = 1'b0;
    sd.spi_mosi    = 1'b0;
    sd.vsd_miso    = 1'b0;
    sd.SD_MISO     = 1'b0;
    repeat (3) tick();
    test_reset();
    test_switch();
    test_route_virtual();
    test_burst();
    test_cancel();
    test_reset_in_gap();
    test_led();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
